// File: rtl/replay_sequencer.sv
// replay_sequencer: replays ROM messages onto a valid/ready port, free-run or single-step.
// Define STEP_DEBOUNCE_EN to add a DEBOUNCE_CYCLES stability filter on the step button.
module replay_sequencer #(
  parameter int ADDR_W          = 10,
  parameter int MSG_W           = 64,
  parameter int NUM_MSGS        = 1000,
  parameter int GAP_CYCLES      = 16,
  parameter int DEBOUNCE_CYCLES = 50
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              run_mode,
  input  logic              step,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_rd,
  input  logic [MSG_W-1:0]  rom_data,
  output logic [MSG_W-1:0]  msg_data,
  output logic              msg_valid,
  input  logic              msg_ready,
  output logic [ADDR_W:0]   msg_count,
  output logic              busy,
  output logic              done
);
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, OFFER, GAP, WAIT_STEP, DONE} state_t;
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0] count_q, count_d;
  logic [MSG_W-1:0] data_q, data_d;
  logic [GW-1:0] gap_q, gap_d;
  logic sync1_q, sync2_q, step_prev_q, step_filt, step_rise, last;
`ifdef STEP_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1) > 0 ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  logic [DW-1:0] deb_q, deb_d;
  logic filt_q, filt_d;
  always_comb begin
    deb_d = '0;
    filt_d = filt_q;
    if (sync2_q != filt_q) begin
      filt_d = int'(deb_q) >= DEBOUNCE_CYCLES - 1 ? sync2_q : filt_q;
      deb_d = int'(deb_q) >= DEBOUNCE_CYCLES - 1 ? '0 : deb_q + 1'b1;
    end
  end
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      deb_q <= '0;
      filt_q <= 1'b0;
    end else begin
      deb_q <= deb_d;
      filt_q <= filt_d;
    end
  end
  assign step_filt = filt_q;
`else
  assign step_filt = sync2_q;
`endif
  assign step_rise = step_filt & ~step_prev_q;
  assign last = int'(count_q) == NUM_MSGS - 1;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    count_d = count_q;
    data_d = data_q;
    gap_d = gap_q;
    if (start) begin
      state_d = NUM_MSGS == 0 ? DONE : run_mode ? FETCH : WAIT_STEP;
      addr_d = '0;
      count_d = '0;
    end else begin
      case (state_q)
        FETCH: state_d = LOAD;
        LOAD: begin
          data_d = rom_data;
          state_d = OFFER;
        end
        OFFER: if (msg_ready) begin
          count_d = count_q + 1'b1;
          addr_d = last ? addr_q : addr_q + 1'b1;
          gap_d = '0;
          state_d = last ? DONE : !run_mode ? WAIT_STEP : GAP_CYCLES > 0 ? GAP : FETCH;
        end
        GAP: begin
          gap_d = gap_q + 1'b1;
          state_d = int'(gap_q) >= GAP_CYCLES - 1 ? FETCH : GAP;
        end
        WAIT_STEP: state_d = run_mode || step_rise ? FETCH : WAIT_STEP;
        default: ;
      endcase
    end
  end
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q <= '0;
      count_q <= '0;
      data_q <= '0;
      gap_q <= '0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      step_prev_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      count_q <= count_d;
      data_q <= data_d;
      gap_q <= gap_d;
      sync1_q <= step;
      sync2_q <= sync1_q;
      step_prev_q <= step_filt;
    end
  end
  assign rom_addr = addr_q;
  assign rom_rd = state_q == FETCH;
  assign msg_data = data_q;
  assign msg_valid = state_q == OFFER;
  assign msg_count = count_q;
  assign busy = state_q != IDLE && state_q != DONE;
  assign done = state_q == DONE;
endmodule

// File: tb/tb_replay_sequencer.sv
// tb_replay_sequencer: directed table plus hand sequences for replay_sequencer (NUM_MSGS=4, GAP_CYCLES=2).
module tb_replay_sequencer;
  logic sys_clk = 0, rst_n = 0, start = 0, run_mode = 1, step = 0, msg_ready = 1;
  logic [3:0] rom_addr;
  logic rom_rd, msg_valid, busy, done;
  logic [63:0] rom_data = '0, msg_data;
  logic [4:0] msg_count;
  int total = 0, bad = 0;

  typedef struct {
    logic st, v, rd, bz, dn;
    logic [4:0] cnt;
    logic [3:0] ad;
    logic [2:0] ds;
  } vec_t;
  vec_t tv[20];

  replay_sequencer #(.ADDR_W(4), .MSG_W(64), .NUM_MSGS(4), .GAP_CYCLES(2), .DEBOUNCE_CYCLES(50)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .start(start), .run_mode(run_mode), .step(step),
    .rom_addr(rom_addr), .rom_rd(rom_rd), .rom_data(rom_data), .msg_data(msg_data),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_count(msg_count), .busy(busy), .done(done));

  always #5 sys_clk = ~sys_clk;

  function automatic logic [63:0] rv(input int k);
    return {16'hBEEF, 16'(k), 32'h1357_9BDF + 32'(k) * 32'h1111};
  endfunction

  always @(posedge sys_clk) if (rom_rd) rom_data <= rv(int'(rom_addr));

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!msg_valid && n < 50) begin
      tick();
      n++;
    end
    chk(nm, msg_valid, 1'b1);
  endtask

  task automatic pulse(input int len);
    step = 1;
    repeat (len) tick();
    step = 0;
  endtask

  initial begin
    int n;
    tv = '{
      '{1,0,1,1,0,0,0,0}, '{0,0,0,1,0,0,0,0}, '{0,1,0,1,0,0,0,1}, '{0,0,0,1,0,1,1,1},
      '{0,0,0,1,0,1,1,1}, '{0,0,1,1,0,1,1,1}, '{0,0,0,1,0,1,1,1}, '{0,1,0,1,0,1,1,2},
      '{0,0,0,1,0,2,2,2}, '{0,0,0,1,0,2,2,2}, '{0,0,1,1,0,2,2,2}, '{0,0,0,1,0,2,2,2},
      '{0,1,0,1,0,2,2,3}, '{0,0,0,1,0,3,3,3}, '{0,0,0,1,0,3,3,3}, '{0,0,1,1,0,3,3,3},
      '{0,0,0,1,0,3,3,3}, '{0,1,0,1,0,3,3,4}, '{0,0,0,0,1,4,3,4}, '{0,0,0,0,1,4,3,4}};
    repeat (3) tick();
    chk("reset_state", {msg_valid, rom_rd, busy, done, msg_count, rom_addr, msg_data}, '0);
    rst_n = 1;
    tick();
    chk("idle_state", {msg_valid, rom_rd, busy, done, msg_count, rom_addr, msg_data}, '0);
    for (int i = 0; i < 20; i++) begin
      start = tv[i].st;
      tick();
      chk($sformatf("freerun_vec%0d", i), {msg_valid, rom_rd, busy, done, msg_count, rom_addr, msg_data},
          {tv[i].v, tv[i].rd, tv[i].bz, tv[i].dn, tv[i].cnt, tv[i].ad, tv[i].ds == 0 ? 64'd0 : rv(int'(tv[i].ds) - 1)});
    end
    msg_ready = 0;
    start = 1;
    tick();
    start = 0;
    wait_valid("stall_offer");
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("stall_hold%0d", i), {msg_valid, msg_data, msg_count}, {1'b1, rv(0), 5'd0});
    end
    msg_ready = 1;
    tick();
    chk("stall_release", {msg_valid, msg_count}, {1'b0, 5'd1});
    n = 0;
    while (msg_count != 2 && n < 50) begin
      tick();
      n++;
    end
    chk("restart_cnt2", msg_count, 5'd2);
    msg_ready = 0;
    wait_valid("restart_offer3");
    chk("restart_data3", msg_data, rv(2));
    start = 1;
    tick();
    start = 0;
    chk("restart_drop", {msg_valid, msg_count, rom_rd, rom_addr}, {1'b0, 5'd0, 1'b1, 4'd0});
    wait_valid("restart_offer0");
    chk("restart_data0", msg_data, rv(0));
    rst_n = 0;
    tick();
    chk("midrun_reset", {msg_valid, busy, done, msg_count, rom_rd, rom_addr, msg_data}, '0);
    repeat (4) tick();
    rst_n = 1;
    tick();
    chk("after_reset", {msg_valid, busy, done, msg_count, rom_rd, rom_addr, msg_data}, '0);
    run_mode = 0;
    start = 1;
    tick();
    start = 0;
    chk("step_wait", {busy, msg_valid, rom_rd}, 3'b100);
    repeat (20) tick();
    chk("step_nostep", {busy, msg_valid}, 2'b10);
    pulse(100);
    wait_valid("step_offer1");
    chk("step_data1", msg_data, rv(0));
    pulse(10);
    repeat (20) tick();
    msg_ready = 1;
    tick();
    chk("step_xfer1", msg_count, 5'd1);
    repeat (1000) tick();
    chk("step_extra_ignored", {msg_count, msg_valid}, {5'd1, 1'b0});
    pulse(100);
    repeat (1000) tick();
    chk("step_xfer2", msg_count, 5'd2);
    pulse(100);
    repeat (1000) tick();
    chk("step_xfer3", {msg_count, done, busy}, {5'd3, 1'b0, 1'b1});
`ifdef STEP_DEBOUNCE_EN
    pulse(20);
    repeat (200) tick();
    chk("debounce_glitch", {msg_count, done}, {5'd3, 1'b0});
    pulse(60);
    repeat (200) tick();
    chk("debounce_press", {msg_count, done}, {5'd4, 1'b1});
`else
    pulse(20);
    repeat (200) tick();
    chk("short_press", {msg_count, done}, {5'd4, 1'b1});
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
